// File: rtl/product_bcd_converter_if.sv
// Handshake/result bundle between the Booth multiplier side and the BCD converter.
interface product_bcd_converter_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  in_valid;
  logic [WIDTH-1:0]      in_product;
  logic                  in_ready;
  logic                  busy;
  logic                  done_sig;
  logic                  sign;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overrun;

  // Producer side: presents the product, observes status and result.
  modport master (
    output in_valid, in_product,
    input  in_ready, busy, done_sig, sign, bcd, overrun
  );

  // Converter side.
  modport slave (
    input  in_valid, in_product,
    output in_ready, busy, done_sig, sign, bcd, overrun
  );
endinterface

// File: rtl/product_bcd_converter.sv
// Signed product to sign-magnitude packed BCD converter.
// Captures a two's-complement product on a strobe, runs a one-bit-per-clock
// double-dabble, then publishes sign + BCD digits with a one-cycle done pulse.
// All outputs come straight from flops; bcd/sign only change on completion.
module product_bcd_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  product_bcd_converter_if.slave   bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t          state, state_next;
  logic            sign_r;
  logic [WIDTH-1:0] mag;
  logic [BW-1:0]   bcd_work;
  logic [BW-1:0]   bcd_adj;
  logic [CW-1:0]   cnt;

  logic            in_ready_r;
  logic            busy_r;
  logic            done_r;
  logic            sign_out;
  logic [BW-1:0]   bcd_out;
  logic            overrun_r;

  // Per-digit add-3 correction: any digit >= 5 would exceed 9 after the shift.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
      assign bcd_adj[4*gi +: 4] = (bcd_work[4*gi +: 4] >= 4'd5)
                                ? bcd_work[4*gi +: 4] + 4'd3
                                : bcd_work[4*gi +: 4];
    end
  endgenerate

  // Next-state logic; strobes outside IDLE never change the sequence.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid) state_next = CONV;
      CONV:    if (cnt == CW'(WIDTH - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Capture and shift engine: magnitude shifts out MSB-first into the BCD work register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r   <= 1'b0;
      mag      <= '0;
      bcd_work <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          sign_r   <= bus.in_product[WIDTH-1];
          // 0x8000 negates to itself, which is exactly the unsigned magnitude 32768.
          mag      <= bus.in_product[WIDTH-1] ? (~bus.in_product + WIDTH'(1))
                                              : bus.in_product;
          bcd_work <= '0;
          cnt      <= '0;
        end
        CONV: begin
          bcd_work <= (bcd_adj << 1) | BW'(mag[WIDTH-1]);
          mag      <= mag << 1;
          cnt      <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered status and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      sign_out   <= 1'b0;
      bcd_out    <= '0;
      overrun_r  <= 1'b0;
    end else begin
      in_ready_r <= (state_next == IDLE);
      busy_r     <= (state_next != IDLE);
      done_r     <= (state == DONE);
      if (state == DONE) begin
        bcd_out  <= bcd_work;
        // A zero magnitude is always reported as positive.
        sign_out <= sign_r & (|bcd_work);
      end
      if (bus.in_valid && state != IDLE) overrun_r <= 1'b1;
    end
  end

  assign bus.in_ready = in_ready_r;
  assign bus.busy     = busy_r;
  assign bus.done_sig = done_r;
  assign bus.sign     = sign_out;
  assign bus.bcd      = bcd_out;
  assign bus.overrun  = overrun_r;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed bench for product_bcd_converter: table of products with
// hand-computed BCD results, plus back-to-back, overrun and mid-run reset sequences.
module tb_product_bcd_converter;
  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic        cur_sign;
  logic [19:0] cur_bcd;

  product_bcd_converter_if #(.WIDTH(16), .DIGITS(5)) bus ();

  product_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] prod;
    logic        exp_sign;
    logic [19:0] exp_bcd;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Strobe one product, optionally inject a second strobe n cycles in,
  // then watch for done with a cycle bound.
  task automatic convert(input logic [15:0] p, input logic es, input logic [19:0] eb,
                         input int extra_at);
    int n;
    int busy_n;
    bit hold_ok;
    bit seen;
    bus.in_valid   = 1'b1;
    bus.in_product = p;
    @(posedge clk); #1;
    bus.in_valid   = 1'b0;
    bus.in_product = 16'($urandom);
    busy_n  = 0;
    hold_ok = 1;
    seen    = 0;
    n       = 0;
    if (bus.busy) busy_n++;
    while (n < 40 && !seen) begin
      if (bus.bcd !== cur_bcd || bus.sign !== cur_sign) hold_ok = 0;
      if (extra_at != 0 && n == extra_at) begin
        bus.in_valid   = 1'b1;
        bus.in_product = 16'h7777;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (bus.done_sig) seen = 1;
      else if (bus.busy) busy_n++;
    end
    bus.in_valid = 1'b0;
    check("latency", n, 17);
    check("hold_prev", {31'd0, hold_ok}, 32'd1);
    check("busy_cycles", busy_n, 17);
    check("busy_at_done", {31'd0, bus.busy}, 32'd0);
    check("ready_at_done", {31'd0, bus.in_ready}, 32'd1);
    check("sign", {31'd0, bus.sign}, {31'd0, es});
    check("bcd", {12'd0, bus.bcd}, {12'd0, eb});
    $display("conv prod=%h sign=%0d bcd=%h cycles=%0d", p, bus.sign, bus.bcd, n);
    cur_sign = es;
    cur_bcd  = eb;
  endtask

  initial begin
    int dcount;
    vecs[0] = '{16'h0000, 1'b0, 20'h00000};
    vecs[1] = '{16'h3F01, 1'b0, 20'h16129};
    vecs[2] = '{16'hC080, 1'b1, 20'h16256};
    vecs[3] = '{16'h4000, 1'b0, 20'h16384};
    vecs[4] = '{16'h8000, 1'b1, 20'h32768};
    vecs[5] = '{16'hFFFF, 1'b1, 20'h00001};
    vecs[6] = '{16'h7FFF, 1'b0, 20'h32767};
    vecs[7] = '{16'h0009, 1'b0, 20'h00009};
    vecs[8] = '{16'hFFF6, 1'b1, 20'h00010};
    vecs[9] = '{16'h2710, 1'b0, 20'h10000};

    bus.in_valid   = 1'b0;
    bus.in_product = 16'h0;
    cur_sign = 1'b0;
    cur_bcd  = 20'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done_sig}, 32'd0);
    check("rst_sign", {31'd0, bus.sign}, 32'd0);
    check("rst_bcd", {12'd0, bus.bcd}, 32'd0);
    check("rst_overrun", {31'd0, bus.overrun}, 32'd0);
    #19 rst_n = 1'b1;
    @(negedge clk);

    // Table vectors, each followed by a check that done drops after one cycle.
    for (int i = 0; i < 10; i++) begin
      convert(vecs[i].prod, vecs[i].exp_sign, vecs[i].exp_bcd, 0);
      @(posedge clk); #1;
      check("done_one_cycle", {31'd0, bus.done_sig}, 32'd0);
    end

    // Back-to-back: the second strobe lands in the done_sig cycle.
    convert(16'h0064, 1'b0, 20'h00100, 0);
    convert(16'hC080, 1'b1, 20'h16256, 0);
    check("b2b_overrun", {31'd0, bus.overrun}, 32'd0);
    @(posedge clk); #1;

    // Overrun: second strobe 5 clocks in is dropped, flag becomes sticky.
    convert(16'h0064, 1'b0, 20'h00100, 5);
    check("overrun_set", {31'd0, bus.overrun}, 32'd1);
    dcount = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (bus.done_sig) dcount++;
    end
    check("overrun_single_done", dcount, 0);
    check("overrun_sticky", {31'd0, bus.overrun}, 32'd1);

    // Reset mid-conversion aborts without a done pulse.
    bus.in_valid   = 1'b1;
    bus.in_product = 16'h1234;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_bcd", {12'd0, bus.bcd}, 32'd0);
    check("mid_rst_sign", {31'd0, bus.sign}, 32'd0);
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rst_ready", {31'd0, bus.in_ready}, 32'd1);
    check("mid_rst_overrun", {31'd0, bus.overrun}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (bus.done_sig) dcount++;
    end
    check("mid_rst_no_done", dcount, 0);
    cur_sign = 1'b0;
    cur_bcd  = 20'h0;
    convert(16'h03E8, 1'b0, 20'h01000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
